// File: rtl/tick_pkg.sv
// Shared types and constants for the tick_control start/stop/clear prescaler block.
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/edge_detect.sv
// Button rising-edge detector; with TICK_CONTROL_SYNC_EN defined the input first
// passes a SYNC_DEPTH-flop synchronizer, otherwise it is sampled directly.
module edge_detect
    import tick_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic raw;
    logic sample_q;
    logic prev_q;

`ifdef TICK_CONTROL_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], btn_i};
        end
    end

    assign raw = sync_q[SYNC_DEPTH-1];
`else
    assign raw = btn_i;
`endif

    // prev_q resets to 0 so a button already held at reset release still yields an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so prev_q takes the old sample_q, forming a two-stage shift.
            sample_q <= raw;
            prev_q   <= sample_q;
        end
    end

    assign pulse_o = sample_q & ~prev_q;

endmodule

// File: rtl/tick_control.sv
// Start/stop/clear control FSM with a DIVISOR-cycle prescaler producing ENA ticks.
// Define TICK_CONTROL_SYNC_EN to add input synchronizers (edge latency 3 instead of 1).
module tick_control
    import tick_pkg::*;
#(
    parameter int DIVISOR = 50000,
    parameter int WIDTH   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic START,
    input  logic STOP,
    input  logic CLEAR,
    output logic ENA,
    output logic CLEAR_N,
    output logic RUNNING
);

    logic start_edge;
    logic stop_edge;
    logic clear_edge;

    edge_detect u_start (.clk_i(CLOCK), .rst_i(RESET), .btn_i(START), .pulse_o(start_edge));
    edge_detect u_stop  (.clk_i(CLOCK), .rst_i(RESET), .btn_i(STOP),  .pulse_o(stop_edge));
    edge_detect u_clear (.clk_i(CLOCK), .rst_i(RESET), .btn_i(CLEAR), .pulse_o(clear_edge));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] presc_q, presc_d;
    logic             ena_q, ena_d;
    logic             clear_n_q, clear_n_d;
    logic             at_top;

    assign at_top = (presc_q == WIDTH'(DIVISOR - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        presc_d   = presc_q;
        ena_d     = 1'b0;
        clear_n_d = 1'b1;

        // Clear wins over everything and also suppresses a tick due this cycle.
        if (clear_edge) begin
            state_d   = IDLE;
            presc_d   = '0;
            clear_n_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_edge) state_d = RUN;
                end
                RUN: begin
                    ena_d   = at_top;
                    presc_d = at_top ? '0 : presc_q + WIDTH'(1);
                    if (stop_edge) state_d = PAUSE;
                end
                PAUSE: begin
                    if (start_edge) state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ena_q     <= 1'b0;
            clear_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ena_q     <= ena_d;
            clear_n_q <= clear_n_d;
        end
    end

    assign ENA     = ena_q;
    assign CLEAR_N = clear_n_q;
    assign RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_tick_control.sv
// Self-checking bench for tick_control: DIVISOR=4 and DIVISOR=1 instances share stimulus
// and are compared every cycle against a run-count based reference model.
module tb_tick_control;

`ifdef TICK_CONTROL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic ena_a, clrn_a, run_a;
    logic ena_b, clrn_b, run_b;

    always #5 clk = ~clk;

    tick_control #(.DIVISOR(4)) dut_a (
        .CLOCK(clk), .RESET(rst), .START(start), .STOP(stop), .CLEAR(clear),
        .ENA(ena_a), .CLEAR_N(clrn_a), .RUNNING(run_a)
    );

    tick_control #(.DIVISOR(1)) dut_b (
        .CLOCK(clk), .RESET(rst), .START(start), .STOP(stop), .CLEAR(clear),
        .ENA(ena_b), .CLEAR_N(clrn_b), .RUNNING(run_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: button history {clear,stop,start}, mode, and RUN cycles since clear.
    logic [2:0] hist [0:LAT];
    int         m_mode;
    int         m_runs [2];
    logic       m_ena  [2];
    logic       m_clrn;

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= LAT; i++) hist[i] = 3'b000;
        m_mode = M_IDLE;
        m_clrn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_runs[k] = 0;
            m_ena[k]  = 1'b0;
        end
    endtask

    task automatic model_update(input logic [2:0] btn);
        logic [2:0] p;
        p = hist[LAT-1] & ~hist[LAT];
        if (p[2]) begin
            m_mode = M_IDLE;
            m_clrn = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_runs[k] = 0;
                m_ena[k]  = 1'b0;
            end
        end else begin
            m_clrn = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_ena[k] = (m_mode == M_RUN) && (((m_runs[k] + 1) % div_of(k)) == 0);
                if (m_mode == M_RUN) m_runs[k]++;
            end
            case (m_mode)
                M_IDLE:  if (p[0]) m_mode = M_RUN;
                M_RUN:   if (p[1]) m_mode = M_PAUSE;
                default: if (p[0]) m_mode = M_RUN;
            endcase
        end
        for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn;
    endtask

    task automatic check_outputs();
        check("ena_div4",      ena_a,  m_ena[0]);
        check("ena_div1",      ena_b,  m_ena[1]);
        check("clear_n_div4",  clrn_a, m_clrn);
        check("clear_n_div1",  clrn_b, m_clrn);
        check("running_div4",  run_a,  m_mode == M_RUN);
        check("running_div1",  run_b,  m_mode == M_RUN);
        check("ena_during_clr", ena_a & ~clrn_a, 1'b0);
    endtask

    task automatic check_reset_values();
        check("rst_ena_div4",     ena_a,  1'b0);
        check("rst_clear_n_div4", clrn_a, 1'b1);
        check("rst_running_div4", run_a,  1'b0);
        check("rst_ena_div1",     ena_b,  1'b0);
        check("rst_clear_n_div1", clrn_b, 1'b1);
        check("rst_running_div1", run_b,  1'b0);
    endtask

    // Drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic s, input logic t, input logic c);
        start = s;
        stop  = t;
        clear = c;
        @(posedge clk);
        if (rst) model_reset();
        else     model_update({c, t, s});
        @(negedge clk);
        check_outputs();
    endtask

    task automatic settle_idle();
        step(1'b0, 1'b0, 1'b1);
        repeat (LAT + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int   lat_seen;
        int   clrn_lows;
        int   ena_cnt;
        int   rises;
        logic prev_run;
        logic s, t, c;

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Single START pulse from IDLE: RUN latency and the 4/8/12 tick pattern.
        lat_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (run_a && lat_seen == 0) lat_seen = i + 1;
            check("ena_pattern", ena_a, (i > LAT) && ((i - LAT) % 4 == 0));
        end
        check("start_latency", lat_seen, LAT + 1);
        settle_idle();

        // Run briefly, pause for 10 cycles, resume from the held prescaler.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !run_a; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        settle_idle();

        // START, STOP and CLEAR together while running: clear wins.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !run_a; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        clrn_lows = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (!clrn_a) clrn_lows++;
        end
        check("clear_n_low_cycles", clrn_lows, 1);
        check("running_after_clear", run_a, 1'b0);

        // Asynchronous reset while the prescaler sits at 3.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (m_mode == M_RUN && (m_runs[0] % 4) == 3) break;
            step(1'b0, 1'b0, 1'b0);
        end
        check("reached_presc3", (m_mode == M_RUN) && (m_runs[0] % 4 == 3), 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        ena_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (ena_a) ena_cnt++;
        end
        check("ena_after_reset", ena_cnt, 0);

        // START already held high when reset is released still starts the FSM.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (LAT + 2) step(1'b1, 1'b0, 1'b0);
        check("held_start_at_release", run_a, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        settle_idle();

        // START held for 20 cycles: a single transition to RUN.
        rises    = 0;
        prev_run = run_a;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (run_a && !prev_run) rises++;
            prev_run = run_a;
        end
        check("held_start_rises", rises, 1);
        step(1'b0, 1'b0, 1'b0);

        // Random button activity.
        s = 1'b0;
        t = 1'b0;
        c = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(4) == 0)  s = ~s;
            if ($urandom_range(5) == 0)  t = ~t;
            if ($urandom_range(20) == 0) c = ~c;
            step(s, t, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_control.md
TICK_CONTROL -- requirements
Module: tick_control

Interface
REQ-001 Parameter DIVISOR, default 50000, CLOCK cycles per ENA pulse; legal range >= 1.
REQ-002 Parameter WIDTH, default $clog2(DIVISOR) (minimum 1), prescaler width.
REQ-003 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  level button; a rising edge requests run.
REQ-006 STOP  input  1  level button; a rising edge requests pause.
REQ-007 CLEAR  input  1  level button; a rising edge requests clear.
REQ-008 ENA  output  1  one-cycle count-enable pulse to the downstream counter.
REQ-009 CLEAR_N  output  1  active-low one-cycle clear to the downstream counter.
REQ-010 RUNNING  output  1  high while the FSM is in RUN.

Function
REQ-011 Each button SHALL be registered once; the edge is current sample AND NOT previous sample, giving a 1-cycle-wide internal pulse.
REQ-012 Edge detection latency SHALL be 1 cycle from the first CLOCK edge sampling the input high to the internal pulse.
REQ-013 FSM states: IDLE, RUN, PAUSE.
REQ-014 IDLE: start edge -> RUN; stop edge ignored.
REQ-015 RUN: stop edge -> PAUSE; start edge ignored.
REQ-016 PAUSE: start edge -> RUN; stop edge ignored.
REQ-017 Clear edge in any state -> IDLE, prescaler <= 0, CLEAR_N low for exactly the next cycle.
REQ-018 Simultaneous edges: priority CLEAR > STOP > START.
REQ-019 Prescaler counts 0..DIVISOR-1 only in RUN, wraps to 0, holds in PAUSE, is 0 in IDLE.
REQ-020 ENA is registered and SHALL be high for exactly one cycle following each cycle in which the prescaler is DIVISOR-1 in RUN.
REQ-021 First ENA SHALL occur DIVISOR cycles after the first RUN cycle; resuming from PAUSE continues from the held prescaler value.
REQ-022 DIVISOR = 1: ENA high every cycle after each RUN cycle.
REQ-023 ENA SHALL never be high in a cycle in which CLEAR_N is low.
REQ-024 RUNNING is decoded from the state register (no added latency).

Reset
REQ-025 RESET high SHALL immediately force state IDLE, prescaler 0, edge registers 0, ENA 0, CLEAR_N 1, RUNNING 0.
REQ-026 Reset asserted mid-RUN SHALL abort any pending ENA; no pulse after release until a new start edge.
REQ-027 A button already held high at reset release SHALL produce an edge (previous-sample register resets to 0).

Configuration
REQ-028 Macro TICK_CONTROL_SYNC_EN defined: each button passes a 2-flop synchronizer before the edge register, edge latency 3 cycles; synchronizer flops reset to 0.
REQ-029 Macro undefined: no synchronizer, edge latency 1 cycle as in REQ-012; all other behaviour identical.

Structure
REQ-030 Shared package tick_pkg SHALL hold the FSM state typedef (IDLE, RUN, PAUSE) and the synchronizer depth constant (2).
REQ-031 One sub-module edge_detect (optional synchronizer plus rising-edge register) SHALL be instantiated three times, one per button.

Verification (DIVISOR = 4, macro undefined unless stated)
REQ-032 START pulse, hold 12 cycles in RUN -> ENA high in cycles 4, 8, 12 after the first RUN cycle, low otherwise.
REQ-033 RUN 2 cycles, STOP, wait 10, START -> prescaler holds at 2 during PAUSE, first ENA 2 cycles after re-entering RUN.
REQ-034 START, STOP, CLEAR edges in the same cycle from RUN -> IDLE, CLEAR_N low 1 cycle, RUNNING 0, no ENA.
REQ-035 RESET asserted when prescaler = 3 -> ENA stays 0, all outputs at reset values within the same cycle; no ENA after release.
REQ-036 START held high continuously for 20 cycles -> exactly one transition to RUN; no retriggering.
REQ-037 TICK_CONTROL_SYNC_EN defined, START pulse -> RUNNING rises 2 cycles later than in the undefined build.
